pwm_cmd_decoder: RTL and testbench

Command decoder between the SPI receiver and the PWM bank. Takes completed SPI frames (data word plus one-cycle valid pulse), decodes an 8-bit address/command field and a threshold value, and holds per-channel values in shadow registers. On a commit command, it drains all changed channels to the PWM bank one per clock through the PWM threshold-write port. All channels therefore take their new duty cycles within one contiguous burst.

---
 rtl/pwm_cmd_decoder_pkg.sv | 24 ++
 rtl/pwm_cmd_decoder_lsb_prio_enc.sv | 25 ++
 rtl/pwm_cmd_decoder.sv | 184 ++++++++++++++++++
 tb/tb_pwm_cmd_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cmd_decoder_pkg.sv
// pwm_cmd_pkg: shared constants, FSM state type and field-width helper for
// the PWM command decoder.
//   ADDR_BITS   width of the frame address/command field
//   CMD_CLEAR   zero every shadow register and mark every channel dirty
//   CMD_COMMIT  request a drain of dirty channels to the PWM bank
//   state_t     drain FSM states
//   roundup8    round a bit width up to a whole number of bytes
package pwm_cmd_pkg;

    localparam int ADDR_BITS = 8;

    localparam logic [ADDR_BITS-1:0] CMD_CLEAR  = 8'hFE;
    localparam logic [ADDR_BITS-1:0] CMD_COMMIT = 8'hFF;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    function automatic int roundup8(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/pwm_cmd_decoder_lsb_prio_enc.sv
// lsb_prio_enc: combinational lowest-set-bit priority encoder.
//   req  in   width      request vector
//   idx  out  idx_w      index of the lowest set bit of req (0 if none)
//   any  out  1          at least one bit of req is set
module lsb_prio_enc #(
    parameter  int width = 12,
    localparam int idx_w = (width > 1) ? $clog2(width) : 1
) (
    input  logic [width-1:0] req,
    output logic [idx_w-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        // Scan from the top down so the lowest set bit is the last to win.
        for (int unsigned i = width; i > 0; i--) begin
            if (req[i-1]) begin
                idx = idx_w'(i - 1);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder: decodes SPI command frames into PWM threshold writes.
// Frames carry an 8-bit address/command in the top byte and a threshold in
// the low pwm_width bits. With PWM_CMD_SHADOW_EN defined, writes land in
// per-channel shadow registers and a COMMIT drains every dirty channel to the
// PWM bank, one per clock, lowest index first. Without it, each write frame
// goes straight to the PWM bank on the next clock, CLEAR is rejected and
// COMMIT is ignored.
//   clk        in   1          system clock, rising edge
//   nreset     in   1          asynchronous active-low reset
//   spi_data   in   spi_width  received frame, sampled when spi_valid=1
//   spi_valid  in   1          one-cycle frame-complete pulse
//   set_thres  out  1          one-cycle threshold write strobe
//   sel_thres  out  sel_width  channel index of the write
//   new_thres  out  pwm_width  threshold value of the write
//   busy       out  1          drain in progress (tied 0 without shadow)
//   err_count  out  8          saturating count of rejected frames
// Build option: PWM_CMD_SHADOW_EN enables shadow/dirty storage and draining.
module pwm_cmd_decoder
    import pwm_cmd_pkg::*;
#(
    parameter  int pwm_width = 16,
    parameter  int num_pwm   = 12,
    localparam int spi_width = ADDR_BITS + roundup8(pwm_width),
    localparam int sel_width = $clog2(num_pwm)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [spi_width-1:0] spi_data,
    input  logic                 spi_valid,
    output logic                 set_thres,
    output logic [sel_width-1:0] sel_thres,
    output logic [pwm_width-1:0] new_thres,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam logic [ADDR_BITS-1:0] num_pwm_a = ADDR_BITS'(num_pwm);

    logic [ADDR_BITS-1:0] addr;
    logic [pwm_width-1:0] value;
    logic [sel_width-1:0] wr_idx;
    logic                 wr_en;
    logic                 cmt_en;
    logic                 err_en;
    logic                 unused_frame;

    assign addr         = spi_data[spi_width-1 -: ADDR_BITS];
    assign value        = spi_data[pwm_width-1:0];
    assign wr_idx       = addr[sel_width-1:0];
    assign wr_en        = spi_valid && (addr < num_pwm_a);
    assign cmt_en       = spi_valid && (addr == CMD_COMMIT);
    // Padding bits between the address and value fields carry no meaning.
    assign unused_frame = ^spi_data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_count <= '0;
        end else if (err_en && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

`ifdef PWM_CMD_SHADOW_EN

    logic                 clr_en;
    logic [pwm_width-1:0] shadow [num_pwm];
    logic [num_pwm-1:0]   dirty, dirty_n;
    // pend: channels still eligible in the current drain; cleared at and
    // below each channel sent so a rewrite of a sent channel waits for the
    // next commit.
    logic [num_pwm-1:0]   pend, pend_n;
    logic [num_pwm-1:0]   cand;
    logic                 commit_pending, commit_pending_n;
    state_t               state, state_n;
    logic                 fire;
    logic                 any_cand;
    logic [sel_width-1:0] idx;

    assign clr_en = spi_valid && (addr == CMD_CLEAR);
    assign err_en = spi_valid && !(wr_en || clr_en || cmt_en);
    assign cand   = (state == DRAIN) ? (dirty & pend) : dirty;

    lsb_prio_enc #(
        .width (num_pwm)
    ) u_enc (
        .req (cand),
        .idx (idx),
        .any (any_cand)
    );

    always_comb begin
        fire             = any_cand && ((state == DRAIN) || cmt_en);
        dirty_n          = dirty;
        pend_n           = pend;
        state_n          = state;
        commit_pending_n = commit_pending;

        if (fire) begin
            dirty_n[idx] = 1'b0;
            for (int unsigned j = 0; j < num_pwm; j++) begin
                pend_n[j] = (j > 32'(idx));
            end
        end
        // A write landing on the channel being sent keeps it dirty.
        if (wr_en) begin
            dirty_n[wr_idx] = 1'b1;
        end
        if (clr_en) begin
            dirty_n = '1;
            pend_n  = '1;
        end
        if ((state == DRAIN) && cmt_en) begin
            commit_pending_n = 1'b1;
        end

        if (fire && (|(dirty_n & pend_n))) begin
            state_n = DRAIN;
        end else if ((state == DRAIN) && (commit_pending || cmt_en) && (|dirty_n)) begin
            // Back-to-back restart: everything still dirty is eligible again.
            state_n          = DRAIN;
            pend_n           = '1;
            commit_pending_n = 1'b0;
        end else begin
            state_n          = IDLE;
            commit_pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            dirty          <= '0;
            pend           <= '0;
            commit_pending <= 1'b0;
            set_thres      <= 1'b0;
            busy           <= 1'b0;
            sel_thres      <= '0;
            new_thres      <= '0;
            for (int unsigned k = 0; k < num_pwm; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state          <= state_n;
            dirty          <= dirty_n;
            pend           <= pend_n;
            commit_pending <= commit_pending_n;
            set_thres      <= fire;
            busy           <= fire;
            if (fire) begin
                sel_thres <= idx;
                new_thres <= shadow[idx];
            end
            if (clr_en) begin
                for (int unsigned k = 0; k < num_pwm; k++) begin
                    shadow[k] <= '0;
                end
            end else if (wr_en) begin
                shadow[wr_idx] <= value;
            end
        end
    end

`else

    assign err_en = spi_valid && !(wr_en || cmt_en);
    assign busy   = 1'b0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            set_thres <= 1'b0;
            sel_thres <= '0;
            new_thres <= '0;
        end else begin
            set_thres <= wr_en;
            if (wr_en) begin
                sel_thres <= wr_idx;
                new_thres <= value;
            end
        end
    end

`endif

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// tb_pwm_cmd_decoder: directed plus randomized frames checked cycle by cycle
// against a behavioural model of the decoder (shadow and pass-through
// builds, selected by PWM_CMD_SHADOW_EN).
module tb_pwm_cmd_decoder;

    localparam int PW = 16;
    localparam int NP = 12;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          nreset;
    logic [SW-1:0] spi_data;
    logic          spi_valid;
    logic          set_thres;
    logic [3:0]    sel_thres;
    logic [PW-1:0] new_thres;
    logic          busy;
    logic [7:0]    err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_cmd_decoder #(
        .pwm_width (PW),
        .num_pwm   (NP)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .spi_data  (spi_data),
        .spi_valid (spi_valid),
        .set_thres (set_thres),
        .sel_thres (sel_thres),
        .new_thres (new_thres),
        .busy      (busy),
        .err_count (err_count)
    );

    // Reference model state
    logic [PW-1:0] m_shadow [NP];
    bit            m_dirty  [NP];
    bit            m_sent   [NP];
    bit            m_drain;
    bit            m_pending;
    int            m_err;
    bit            e_set;
    bit            e_busy;
    int            e_sel;
    logic [PW-1:0] e_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_shadow[i] = '0;
            m_dirty[i]  = 1'b0;
            m_sent[i]   = 1'b0;
        end
        m_drain   = 1'b0;
        m_pending = 1'b0;
        m_err     = 0;
        e_set     = 1'b0;
        e_busy    = 1'b0;
        e_sel     = 0;
        e_val     = '0;
    endtask

    // Advance the model by one clock given the frame presented before the edge.
    task automatic model_step(input bit v, input int addr, input logic [PW-1:0] value);
        int pick;
        bit left;
        bit any_dirty;
        pick  = -1;
        e_set = 1'b0;
`ifdef PWM_CMD_SHADOW_EN
        if (m_drain || (v && addr == 255)) begin
            for (int i = NP - 1; i >= 0; i--) begin
                if (m_dirty[i] && !m_sent[i]) pick = i;
            end
        end
        if (pick >= 0) begin
            e_set          = 1'b1;
            e_sel          = pick;
            e_val          = m_shadow[pick];
            m_dirty[pick]  = 1'b0;
            m_sent[pick]   = 1'b1;
        end
        if (v) begin
            if (addr < NP) begin
                m_shadow[addr] = value;
                m_dirty[addr]  = 1'b1;
            end else if (addr == 254) begin
                for (int i = 0; i < NP; i++) begin
                    m_shadow[i] = '0;
                    m_dirty[i]  = 1'b1;
                    m_sent[i]   = 1'b0;
                end
            end else if (addr == 255) begin
                if (m_drain) m_pending = 1'b1;
            end else if (m_err < 255) begin
                m_err++;
            end
        end
        left      = 1'b0;
        any_dirty = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (m_dirty[i] && !m_sent[i]) left = 1'b1;
            if (m_dirty[i]) any_dirty = 1'b1;
        end
        if (e_set && left) begin
            m_drain = 1'b1;
        end else if (m_drain && m_pending && any_dirty) begin
            m_drain   = 1'b1;
            m_pending = 1'b0;
            for (int i = 0; i < NP; i++) m_sent[i] = 1'b0;
        end else begin
            m_drain   = 1'b0;
            m_pending = 1'b0;
            for (int i = 0; i < NP; i++) m_sent[i] = 1'b0;
        end
        e_busy = e_set;
`else
        if (v && addr < NP) begin
            e_set = 1'b1;
            e_sel = addr;
            e_val = value;
        end
        if (v && addr >= NP && addr != 255 && m_err < 255) m_err++;
        e_busy = 1'b0;
`endif
    endtask

    // One clock: present a frame (or idle), step the model, compare outputs.
    task automatic cycle(input bit v, input int addr, input logic [PW-1:0] value);
        spi_valid            = v;
        spi_data             = '0;
        spi_data[SW-1 -: 8]  = 8'(addr);
        spi_data[PW-1:0]     = value;
        @(posedge clk);
        model_step(v, addr, value);
        #1;
        spi_valid = 1'b0;
        check("set_thres", {31'd0, set_thres}, {31'd0, e_set});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("err_count", {24'd0, err_count}, m_err);
        if (e_set) begin
            check("sel_thres", {28'd0, sel_thres}, e_sel);
            check("new_thres", {16'd0, new_thres}, {16'd0, e_val});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0);
    endtask

    initial begin
        int r;
        int a;
        nreset    = 1'b0;
        spi_valid = 1'b0;
        spi_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_set_thres", {31'd0, set_thres}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err_count", {24'd0, err_count}, 0);
        check("rst_sel_thres", {28'd0, sel_thres}, 0);
        check("rst_new_thres", {16'd0, new_thres}, 0);
        @(negedge clk);
        nreset = 1'b1;

        // Rejected frames and saturation
        cycle(1'b1, 'h0C, 16'h5555);
        check("err_first", {24'd0, err_count}, 1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 'h80, 16'($urandom));
        check("err_saturated", {24'd0, err_count}, 255);

        // Single channel then commit
        cycle(1'b1, 3, 16'h1234);
        cycle(1'b1, 255, '0);
        idle(2);

        // Three channels, ascending drain order
        cycle(1'b1, 11, 16'hAAAA);
        cycle(1'b1, 0, 16'h0001);
        cycle(1'b1, 5, 16'h00FF);
        cycle(1'b1, 255, '0);
        idle(4);

        // CLEAR then COMMIT
        cycle(1'b1, 254, '0);
        cycle(1'b1, 255, '0);
        idle(13);

        // Write to an already-sent channel plus COMMIT mid-drain
        for (int i = 0; i < NP; i++) cycle(1'b1, i, 16'($urandom));
        cycle(1'b1, 255, '0);
        idle(4);
        cycle(1'b1, 2, 16'h0BEE);
        cycle(1'b1, 255, '0);
        idle(14);

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++) cycle(1'b1, i, 16'($urandom));
        cycle(1'b1, 255, '0);
        idle(2);
        nreset = 1'b0;
        #1;
        check("midrst_set_thres", {31'd0, set_thres}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_err_count", {24'd0, err_count}, 0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        cycle(1'b1, 255, '0);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                cycle(1'b0, 0, '0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      a = int'($urandom_range(0, NP - 1));
                else if (r < 82) a = 255;
                else if (r < 87) a = 254;
                else             a = int'($urandom_range(NP, 253));
                cycle(1'b1, a, 16'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
